// File: rtl/mem_wb_stage_if.sv
// MEM -> WB packet bundle: instruction qualifier, load data, ALU result and
// write-back control as presented by the data-memory stage.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] reg_dest;
    logic              reg_write;
    logic              mem_to_reg;
    logic [1:0]        load_size;
    logic              load_signed;

    modport master (
        output in_valid, mem_data, alu_result, reg_dest,
               reg_write, mem_to_reg, load_size, load_signed
    );

    modport slave (
        input  in_valid, mem_data, alu_result, reg_dest,
               reg_write, mem_to_reg, load_size, load_signed
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: load alignment/extension, misaligned-load suppression, write-back
// register with stall/flush. Optional retire counter behind `WB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    mem_wb_stage_if.slave     mem_in,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic              misalign_err,
    output logic [DATA_W-1:0] err_addr,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_fmt;
    logic [DATA_W-1:0] wdata_next;
    logic              misalign;
    logic              capture;

    logic              valid_q;
    logic              reg_write_q;
    logic              mis_q;
    logic [REG_AW-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    always_comb begin
        ld_byte = mem_in.mem_data[7:0];
        case (mem_in.alu_result[1:0])
            2'd1:    ld_byte = mem_in.mem_data[15:8];
            2'd2:    ld_byte = mem_in.mem_data[23:16];
            2'd3:    ld_byte = mem_in.mem_data[31:24];
            default: ld_byte = mem_in.mem_data[7:0];
        endcase
        ld_half = mem_in.alu_result[1] ? mem_in.mem_data[31:16] : mem_in.mem_data[15:0];
    end

    // Reserved size 11 behaves as a word, both for formatting and alignment.
    always_comb begin
        ld_fmt   = mem_in.mem_data;
        misalign = 1'b0;
        case (mem_in.load_size)
            2'b01: begin
                ld_fmt   = {{(DATA_W-16){mem_in.load_signed & ld_half[15]}}, ld_half};
                misalign = mem_in.alu_result[0];
            end
            2'b10: begin
                ld_fmt   = {{(DATA_W-8){mem_in.load_signed & ld_byte[7]}}, ld_byte};
                misalign = 1'b0;
            end
            default: begin
                ld_fmt   = mem_in.mem_data;
                misalign = (mem_in.alu_result[1:0] != 2'b00);
            end
        endcase
        misalign   = misalign & mem_in.mem_to_reg;
        wdata_next = mem_in.mem_to_reg ? ld_fmt : mem_in.alu_result;
    end

    assign capture = mem_in.in_valid & ~flush & ~stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mis_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            misalign_err <= 1'b0;
            err_addr     <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= mem_in.in_valid;
            reg_write_q <= mem_in.reg_write;
            mis_q       <= misalign;
            waddr_q     <= mem_in.reg_dest;
            wdata_q     <= wdata_next;
            // Only the first misaligned address is kept until reset.
            if (capture && misalign && !misalign_err) begin
                misalign_err <= 1'b1;
                err_addr     <= mem_in.alu_result;
            end
        end
    end

    assign rf_we     = valid_q & reg_write_q & ~mis_q & (waddr_q != '0);
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign fwd_valid = rf_we;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (capture) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a packet-level reference
// model; directed cases cover the documented load/misalign/stall/flush examples.
module tb_mem_wb_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              fwd_valid;
    logic              misalign_err;
    logic [DATA_W-1:0] err_addr;
    logic [CNT_W-1:0]  retire_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) mif ();

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .mem_in       (mif.slave),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fwd_valid    (fwd_valid),
        .misalign_err (misalign_err),
        .err_addr     (err_addr),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the packet currently held in WB plus error/count.
    typedef struct {
        bit          valid;
        bit          rw;
        bit          mis;
        int unsigned waddr;
        int unsigned wdata;
    } pkt_t;

    pkt_t        m_pkt;
    bit          m_err;
    int unsigned m_err_addr;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ref_fmt(input int unsigned md, input int unsigned addr,
                                            input int unsigned sz, input bit sg);
        int unsigned v;
        if (sz == 2) begin
            v = (md >> (8 * (addr % 4))) % 256;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (md >> (16 * ((addr / 2) % 2))) % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = md;
        end
        return v;
    endfunction

    function automatic bit ref_misaligned(input bit mtr, input int unsigned addr,
                                          input int unsigned sz);
        if (!mtr) return 1'b0;
        if (sz == 1) return (addr % 2) != 0;
        if (sz == 2) return 1'b0;
        return (addr % 4) != 0;
    endfunction

    function automatic bit exp_we();
        return m_pkt.valid && m_pkt.rw && !m_pkt.mis && (m_pkt.waddr != 0);
    endfunction

    function automatic int unsigned exp_cnt();
`ifdef WB_RETIRE_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_edge();
        bit mis;
        if (!rst_n) begin
            m_pkt      = '{0, 0, 0, 0, 0};
            m_err      = 0;
            m_err_addr = 0;
            m_cnt      = 0;
        end else if (flush) begin
            m_pkt.valid = 0;
        end else if (!stall) begin
            mis = ref_misaligned(mif.mem_to_reg, mif.alu_result, mif.load_size);
            if (mif.in_valid) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (mis && !m_err) begin
                    m_err      = 1;
                    m_err_addr = mif.alu_result;
                end
            end
            m_pkt.valid = mif.in_valid;
            m_pkt.rw    = mif.reg_write;
            m_pkt.mis   = mis;
            m_pkt.waddr = mif.reg_dest;
            m_pkt.wdata = mif.mem_to_reg
                          ? ref_fmt(mif.mem_data, mif.alu_result, mif.load_size, mif.load_signed)
                          : mif.alu_result;
        end
    endtask

    task automatic check_model();
        chk("rf_we", {31'b0, rf_we}, {31'b0, exp_we()});
        chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, exp_we()});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        chk("err_addr", err_addr, m_err_addr);
        chk("retire_cnt", {28'b0, retire_cnt}, exp_cnt());
        if (exp_we()) begin
            chk("rf_waddr", {27'b0, rf_waddr}, m_pkt.waddr);
            chk("rf_wdata", rf_wdata, m_pkt.wdata);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic st, input logic fl,
                         input logic [31:0] md, input logic [31:0] alu, input logic [4:0] rd,
                         input logic rw, input logic mtr, input logic [1:0] sz, input logic sg);
        @(negedge clk);
        rst_n           = r;
        stall           = st;
        flush           = fl;
        mif.in_valid    = v;
        mif.mem_data    = md;
        mif.alu_result  = alu;
        mif.reg_dest    = rd;
        mif.reg_write   = rw;
        mif.mem_to_reg  = mtr;
        mif.load_size   = sz;
        mif.load_signed = sg;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd);
        cycle(1, 1, 0, 0, 32'h0, alu, rd, 1, 0, 2'b00, 0);
    endtask

    task automatic load_op(input logic [31:0] md, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [1:0] sz, input logic sg);
        cycle(1, 1, 0, 0, md, addr, rd, 1, 1, sz, sg);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        mif.in_valid = 0; mif.mem_data = 0; mif.alu_result = 0; mif.reg_dest = 0;
        mif.reg_write = 0; mif.mem_to_reg = 0; mif.load_size = 0; mif.load_signed = 0;
        m_pkt = '{0, 0, 0, 0, 0};
        m_err = 0; m_err_addr = 0; m_cnt = 0;

        cycle(0, 1, 0, 0, 32'hDEAD_BEEF, 32'h1111_2222, 5'd9, 1, 0, 2'b00, 0);
        cycle(0, 1, 0, 0, 32'hDEAD_BEEF, 32'h1111_2222, 5'd9, 1, 0, 2'b00, 0);
        chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        chk("rst_misalign_err", {31'b0, misalign_err}, 32'd0);
        chk("rst_retire_cnt", {28'b0, retire_cnt}, 32'd0);

        alu_op(32'h0000_1234, 5'd5);
        chk("alu_we", {31'b0, rf_we}, 32'd1);
        chk("alu_waddr", {27'b0, rf_waddr}, 32'd5);
        chk("alu_wdata", rf_wdata, 32'h0000_1234);

        load_op(32'h80FF_7F01, 32'h0000_1003, 5'd6, 2'b10, 1);
        chk("lb_signed", rf_wdata, 32'hFFFF_FF80);
        load_op(32'h80FF_7F01, 32'h0000_1003, 5'd6, 2'b10, 0);
        chk("lb_unsigned", rf_wdata, 32'h0000_0080);
        load_op(32'h80FF_7F01, 32'h0000_1000, 5'd6, 2'b01, 1);
        chk("lh_signed", rf_wdata, 32'h0000_7F01);
        load_op(32'h80FF_7F01, 32'h0000_1002, 5'd6, 2'b01, 1);
        chk("lh_hi_signed", rf_wdata, 32'hFFFF_80FF);

        load_op(32'h1234_5678, 32'h0000_0102, 5'd3, 2'b00, 0);
        chk("mis_we", {31'b0, rf_we}, 32'd0);
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_addr", err_addr, 32'h0000_0102);
        load_op(32'h1234_5678, 32'h0000_0201, 5'd4, 2'b01, 0);
        chk("mis2_addr", err_addr, 32'h0000_0102);

        alu_op(32'h0000_0055, 5'd7);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 0, 32'hAAAA_AAAA, 32'h0000_0099 + i, 5'd8, 1, 0, 2'b00, 0);
            chk("stall_wdata", rf_wdata, 32'h0000_0055);
            chk("stall_waddr", {27'b0, rf_waddr}, 32'd7);
            chk("stall_we", {31'b0, rf_we}, 32'd1);
        end
        cycle(1, 1, 1, 1, 32'h0, 32'h0000_0077, 5'd9, 1, 0, 2'b00, 0);
        chk("stall_flush_we", {31'b0, rf_we}, 32'd0);

        alu_op(32'h0000_00AB, 5'd0);
        chk("r0_we", {31'b0, rf_we}, 32'd0);
        cycle(1, 1, 0, 0, 32'h0, 32'h0000_0100, 5'd10, 0, 0, 2'b00, 0);
        chk("store_we", {31'b0, rf_we}, 32'd0);

        alu_op(32'h0000_00CD, 5'd11);
        cycle(0, 1, 1, 0, 32'h0, 32'h0000_00EE, 5'd12, 1, 0, 2'b00, 0);
        chk("rst_stall_we", {31'b0, rf_we}, 32'd0);
        chk("rst_stall_err", {31'b0, misalign_err}, 32'd0);

        for (int i = 0; i < 17; i++) alu_op(32'h100 + i, 5'd1);
`ifdef WB_RETIRE_CNT_EN
        chk("cnt_wrap", {28'b0, retire_cnt}, 32'd1);
`else
        chk("cnt_tied", {28'b0, retire_cnt}, 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [31:0] addr;
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            cycle(($urandom_range(0, 99) >= 2),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  $urandom, addr,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 1) == 1),
                  2'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline stage that sits directly downstream of the data-memory (MEM) stage. It aligns and extends the load data returned by data memory and selects between load data and the ALU result. It registers the write-back packet, with stall and flush control, and drives the register-file write port and the WB forwarding bus. Misaligned loads are detected and suppressed, and a sticky error flag is raised.

Parameters:
DATA_W, 32, datapath width (memory data, ALU result, write data).
REG_AW, 5, register-address width.
CNT_W, 16, retire-counter width (used only with the optional feature).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
in_valid  input  1  MEM stage holds a valid instruction.
stall  input  1  hold the current WB contents.
flush  input  1  squash: the register loads a bubble.
mem_data  input  DATA_W  raw word read from data memory.
alu_result  input  DATA_W  ALU result, also the memory address.
reg_dest  input  REG_AW  destination register.
reg_write  input  1  instruction writes the register file.
mem_to_reg  input  1  1 = load data, 0 = ALU result.
load_size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
load_signed  input  1  sign-extend sub-word loads.
rf_we  output  1  register-file write enable.
rf_waddr  output  REG_AW  register-file write address.
rf_wdata  output  DATA_W  register-file write data.
fwd_valid  output  1  equals rf_we; forwarding-unit qualifier.
misalign_err  output  1  sticky misaligned-load flag.
err_addr  output  DATA_W  address of the first misaligned load.
retire_cnt  output  CNT_W  retired-instruction count (optional feature).

Behaviour:
- Reset (rst_n = 0 at a clock edge), all of these clear:
  - valid_q = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - misalign_err = 0, err_addr = 0, retire_cnt = 0
- Update priority each edge: reset > flush > stall > load.
  - flush: valid_q = 0. Data registers may hold stale values, but rf_we must be 0.
  - stall without flush: all registers hold. The same write is re-presented, which is harmless.
  - load: valid_q = in_valid, and the packet below is captured.
- Latency: inputs present in cycle N appear on rf_* in cycle N+1.
- Load formatting (combinational, before the register), little-endian:
  - Byte k = alu_result[1:0] selects mem_data[8k+7:8k].
  - Halfword: alu_result[1] = 0 selects [15:0]; alu_result[1] = 1 selects [31:16].
  - Extension is sign or zero per load_signed. For word loads, load_signed is ignored.
- Misalignment (only when mem_to_reg = 1):
  - Halfword with alu_result[0] = 1, or word with alu_result[1:0] != 0.
  - A misaligned instruction is captured with its write suppressed (mis_q = 1).
- Write data: rf_wdata is the formatted load data when mem_to_reg = 1, else alu_result.
- Write enable: rf_we = valid_q & reg_write_q & ~mis_q & (rf_waddr != 0). Register $0 is never written.
- misalign_err:
  - Sets on the edge where a valid, non-flushed, non-stalled misaligned load is captured.
  - err_addr latches that alu_result only when misalign_err was 0.
  - Both clear only on reset.
- Simultaneous stall + flush: flush wins.
- Reset asserted mid-stall: reset wins and the packet is discarded.
- Store and branch instructions (reg_write = 0) pass through with rf_we = 0.

Optional Feature:
WB_RETIRE_CNT_EN:
- Defined: retire_cnt increments by 1 on each edge where a valid, non-flushed, non-stalled instruction is captured (any type, including misaligned). It wraps from 2^CNT_W-1 to 0 and clears on reset.
- Undefined: no counter register is built and retire_cnt is tied to 0.

Test Plan:
- Reset: rst_n = 0 for 2 cycles -> rf_we = 0, rf_wdata = 0, misalign_err = 0, retire_cnt = 0.
- ALU write-back: alu_result = 0x0000_1234, reg_dest = 5, reg_write = 1, mem_to_reg = 0 -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x0000_1234.
- Byte and halfword loads from mem_data = 0x80FF_7F01:
  - Byte, addr 0x...3, signed -> rf_wdata = 0xFFFF_FF80.
  - Byte, addr 0x...3, unsigned -> rf_wdata = 0x0000_0080.
  - Halfword, addr 0x...0, signed -> rf_wdata = 0x0000_7F01.
- Misaligned load: word load at addr 0x0000_0102, reg_dest = 3 -> rf_we = 0, misalign_err = 1, err_addr = 0x0000_0102. A second misaligned load at 0x0000_0201 leaves err_addr = 0x0000_0102.
- Stall and flush:
  - Stall for 3 cycles -> rf_* held constant and retire_cnt unchanged.
  - stall = 1 with flush = 1 -> next cycle rf_we = 0.
- Write to register 0 and counter wrap:
  - reg_dest = 0, reg_write = 1 -> rf_we = 0.
  - With WB_RETIRE_CNT_EN and CNT_W = 4, 17 retirements -> retire_cnt = 1.
